// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter FSM states, access owners and default latency/starvation parameters
package mem_arb_pkg;
  typedef enum bit [2:0] {IDLE, BUSY_P, BUSY_D, DONE_P, DONE_D} arb_state_t;
  typedef enum bit {OWN_P, OWN_D} owner_t;
  localparam int MEM_LAT_DEF = 2;
  localparam int MAX_P_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a multi-cycle single-port memory between pipeline port p_* (stalled via p_stall) and DMA port d_* (d_gnt/d_done pulses), driving mem_*; clk, async active-low rst
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int MAX_P = MAX_P_DEF,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_re,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(MAX_P + 1);
  arb_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic p_any, d_win, p_win, last;
  owner_t own;
  always_comb begin
    p_any = p_re | p_we;
    d_win = d_req && (!p_any || starve == SW'(MAX_P));
    p_win = p_any && !d_win;
    last = cnt == '0;
    own = state == BUSY_D ? OWN_D : OWN_P;
    nxt = state;
    case (state)
      IDLE:    nxt = d_win ? BUSY_D : p_win ? BUSY_P : IDLE;
      BUSY_P:  nxt = last ? DONE_P : BUSY_P;
      BUSY_D:  nxt = last ? DONE_D : BUSY_D;
      default: nxt = IDLE;
    endcase
  end
  assign p_stall = rst && p_any && state != DONE_P;
  assign d_done = state == DONE_D;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      starve <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      p_rdata <= '0;
      d_rdata <= '0;
      d_gnt <= 1'b0;
    end else begin
      state <= nxt;
      d_gnt <= state == IDLE && d_win;
      if (state == IDLE) begin
        starve <= p_win && d_req ? starve + SW'(1) : '0;
        if (d_win || p_win) begin
          mem_re <= d_win ? !d_we : p_re && !p_we;
          mem_we <= d_win ? d_we : p_we;
          mem_addr <= d_win ? d_addr : p_addr;
          mem_wdata <= d_win ? d_wdata : p_wdata;
          cnt <= CW'(MEM_LAT - 1);
        end
      end
      if (state == BUSY_P || state == BUSY_D) begin
        if (last) begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          if (mem_re && own == OWN_P) p_rdata <= mem_rdata;
          if (mem_re && own == OWN_D) d_rdata <= mem_rdata;
        end else cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic p_re = 0, p_we = 0, d_req = 0, d_we = 0;
  logic [15:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [15:0] p_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic p_stall, d_gnt, d_done, mem_re, mem_we;
  logic d2_req = 0;
  logic [15:0] d2_addr = 0, d2_rdata, p2_rdata, m2_addr, m2_wdata, m2_rdata;
  logic p2_stall, d2_gnt, d2_done, m2_re, m2_we;
  logic ld = 0;
  logic [7:0] ld_a = 0;
  logic [15:0] ld_d = 0;
  logic [15:0] mem [0:255];
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {int kind; int cyc; logic [15:0] data;} ev_t;
  ev_t q[$];
  localparam int EV_P = 0, EV_G = 1, EV_D = 2;

  mem_arbiter #(.MEM_LAT(2), .MAX_P(4)) dut (
    .clk(clk), .rst(rst), .p_re(p_re), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_arbiter #(.MEM_LAT(1), .MAX_P(4)) dut2 (
    .clk(clk), .rst(rst), .p_re(1'b0), .p_we(1'b0), .p_addr(16'h0), .p_wdata(16'h0),
    .p_rdata(p2_rdata), .p_stall(p2_stall), .d_req(d2_req), .d_we(1'b0), .d_addr(d2_addr),
    .d_wdata(16'h0), .d_gnt(d2_gnt), .d_done(d2_done), .d_rdata(d2_rdata), .mem_re(m2_re),
    .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:0]];
  assign m2_rdata = mem[m2_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int c, input logic [15:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic see(input int kind, input logic [15:0] data);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none (cycle %0d)", kind, data, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_data", {16'h0, data}, {16'h0, e.data});
    end
  endtask

  always @(negedge clk) if (rst) begin
    if ((p_re | p_we) && !p_stall) see(EV_P, p_rdata);
    if (d_gnt) see(EV_G, 16'h0);
    if (d_done) see(EV_D, d_rdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    p_re = 1;
    ld = 1; ld_a = 8'h10; ld_d = 16'hBEEF;
    tick;
    ld = 0;
    @(negedge clk);
    chk("rst_p_stall", p_stall, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_d_done", d_done, 0);
    p_re = 0;
    tick;
    rst = 1;
    tick;
    // read 0x0010
    p_re = 1; p_addr = 16'h0010; s = cyc;
    push(EV_P, s + 3, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_p_stall", p_stall, k < 3);
      chk("t1_mem_re", mem_re, k == 1 || k == 2);
      tick;
    end
    p_re = 0;
    // write 0x1234 -> 0x0020
    p_we = 1; p_addr = 16'h0020; p_wdata = 16'h1234; s = cyc;
    push(EV_P, s + 3, 16'hBEEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_p_stall", p_stall, k < 3);
      chk("t2_mem_we", mem_we, k == 1 || k == 2);
      if (k == 1 || k == 2) begin
        chk("t2_mem_addr", mem_addr, 16'h0020);
        chk("t2_mem_wdata", mem_wdata, 16'h1234);
      end
      tick;
    end
    p_we = 0;
    // simultaneous P read and D read
    p_re = 1; p_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0010; s = cyc;
    push(EV_P, s + 3, 16'h1234);
    push(EV_G, s + 5, 16'h0);
    push(EV_D, s + 7, 16'hBEEF);
    repeat (4) tick;
    p_re = 0;
    repeat (4) tick;
    d_req = 0;
    // starvation: continuous P with D write pending
    p_re = 1; p_addr = 16'h0010; d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h5555; s = cyc;
    for (int i = 0; i < 4; i++) push(EV_P, s + 3 + 4 * i, 16'hBEEF);
    push(EV_G, s + 17, 16'h0);
    push(EV_D, s + 19, 16'hBEEF);
    push(EV_P, s + 23, 16'hBEEF);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k >= 16 && k <= 19) chk("t4_p_stall", p_stall, 1);
      if (k == 16) chk("t4_starve_sat", dut.starve, 4);
      if (k == 22) chk("t4_starve_clr", dut.starve, 0);
      tick;
      if (cyc == s + 20) d_req = 0;
    end
    p_re = 0;
    chk("t4_mem_write", mem[8'h30], 16'h5555);
    // reset during second BUSY_D cycle
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h7777; s = cyc;
    push(EV_G, s + 1, 16'h0);
    tick;
    p_re = 1; p_addr = 16'h0010;
    tick;
    chk("t5_pre_mem_we", mem_we, 1);
    rst = 0;
    #1;
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_re", mem_re, 0);
    chk("t5_d_gnt", d_gnt, 0);
    chk("t5_d_done", d_done, 0);
    chk("t5_p_stall", p_stall, 0);
    d_req = 0; p_re = 0;
    repeat (2) tick;
    rst = 1;
    @(negedge clk);
    chk("t5_state_idle", dut.state, IDLE);
    chk("t5_p_rdata_clr", p_rdata, 0);
    tick;
    p_re = 1; p_addr = 16'h0010; s = cyc;
    push(EV_P, s + 3, 16'hBEEF);
    repeat (4) tick;
    p_re = 0;
    // MEM_LAT=1 D read
    d2_req = 1; d2_addr = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_d_gnt", d2_gnt, k == 1);
      chk("t6_d_done", d2_done, k == 2);
      if (k == 2) chk("t6_d_rdata", d2_rdata, 16'hBEEF);
      tick;
    end
    d2_req = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
